nios_ram_arbiter: RTL and testbench
===================================

Name: nios_ram_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the 2048x32 single-port on-chip NIOS RAM (11-bit word address, 4-bit byteenable, 1-cycle read latency).
- Shares the RAM between the NIOS data master (m0) and the ultrasonic capture engine (m1).
- Policy: round-robin, plus a bounded lock that lets m1 stream sample bursts.
- Sits between the two masters and the RAM's s1 slave; it is the only driver of the RAM.

Parameters:
- ADDR_W, 11, word address width (2048 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_LOCK, 16, maximum consecutive m1 grants while m1_lock is held and m0 is waiting (range 1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address, m1_address  in  ADDR_W  word address per requester
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte lanes
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_writedata, m1_writedata  in  DATA_W  write data
- m0_waitrequest, m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata, m1_readdata  out  DATA_W  read data
- m0_readdatavalid, m1_readdatavalid  out  1  readdata valid strobe
- m1_lock  in  1  m1 asks to keep the grant across consecutive cycles
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  DATA_W/8  to RAM byteenable
- ram_chipselect  out  1  to RAM chipselect
- ram_write  out  1  to RAM write
- ram_writedata  out  DATA_W  to RAM writedata
- ram_clken  out  1  to RAM clken; tied 1
- ram_readdata  in  DATA_W  from RAM readdata, valid one cycle after address is presented

Behaviour:
- Request: reqX = mX_read | mX_write. Read and write asserted together is treated as a write; the read is dropped.
- Grant (combinational, each cycle):
  - One requester only: that requester.
  - Both requesting: the one not granted last (last_gnt register), unless the lock rule applies.
- Lock rule: if last_gnt=m1, m1_lock=1, req1=1 and lock_cnt < MAX_LOCK, grant m1.
- lock_cnt:
  - Increments on each m1 grant while req0=1.
  - Clears on any m0 grant, and on any cycle with m1_lock=0.
  - When it reaches MAX_LOCK, m0 is granted on the next cycle in which both request.
- Accept: mX_waitrequest = reqX & ~gntX. A request is accepted in the cycle its waitrequest is low. No backpressure from the RAM.
- RAM drive: ram_address/byteenable/writedata mux the granted requester. ram_chipselect = any grant. ram_write = granted write.
- With no request: ram_chipselect=0, ram_write=0; address/data hold the m0 values (don't-care).
- Read return pipeline:
  - On an accepted read, register rd_pend=1 and rd_id=requester.
  - Next cycle: mX_readdata = ram_readdata, mX_readdatavalid = rd_pend & (rd_id==X). Latency is exactly 1 cycle after acceptance.
  - Back-to-back reads are allowed, so throughput is 1 access/cycle total.
  - m0_readdata and m1_readdata both carry ram_readdata; only the valid strobe is steered.
- last_gnt updates only on cycles with a grant.
- Reset (async assert, sync release):
  - Registers: last_gnt=m1 (so m0 wins the first tie), lock_cnt=0, rd_pend=0.
  - Outputs: all readdatavalid=0; waitrequest follows its combinational equation (0 when idle).
- Reset asserted mid-read: the pending return is discarded and no readdatavalid is produced after release.
- Write then read to the same address in consecutive cycles: the read returns the new data (the RAM write completes in its cycle).
- Address is not range-checked; ADDR_W bits pass straight through.

Test Plan:
- m0 write 0xDEADBEEF @0x005 (be=0xF), then m0 read @0x005 -> m0_waitrequest=0 both cycles; m0_readdatavalid high 1 cycle after the read with 0xDEADBEEF; m1_readdatavalid stays 0.
- Both masters read continuously, m1_lock=0 -> grants alternate m0,m1,m0,... starting with m0; each readdatavalid toggles every other cycle.
- m1 writes 40 cycles with m1_lock=1 while m0 requests continuously, MAX_LOCK=16 -> m1 gets 16 consecutive grants, then m0 gets 1, then m1 gets 16 more; m0_waitrequest high for 16 cycles at a time.
- m0 writes 0x11223344, then m1 writes 0xAABBCCDD @0x7FF with be=0x3, then m0 reads @0x7FF -> readback 0x1122CCDD.
- m0 and m1 read simultaneously, reset_n pulsed low in the following cycle -> no readdatavalid after release; first tie after reset goes to m0.
- m0 asserts read and write together @0x010 with data 0x5 -> treated as a write; no readdatavalid; a later read returns 0x5.

Source files
------------

// File: rtl/nios_ram_arbiter.sv
// -----------------------------------------------------------------------------
// nios_ram_arbiter
//   Two-requester Avalon-MM arbiter in front of the single-port on-chip NIOS
//   RAM. m0 is the NIOS data master, m1 the ultrasonic capture engine.
//   Round-robin between the two, with a bounded lock that lets m1 stream a
//   burst of up to MAX_LOCK back-to-back accesses while m0 is kept waiting.
//   The RAM has a fixed 1-cycle read latency and never stalls, so an accepted
//   read always returns exactly one cycle later and only the valid strobe has
//   to be steered back to the requester that issued it.
// -----------------------------------------------------------------------------
module nios_ram_arbiter #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic                clk,
   input  logic                reset_n,

   // Requester 0: NIOS data master
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,

   // Requester 1: capture engine
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   input  logic                m1_lock,

   // RAM s1 slave
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata
);

   // Lock counter is 8 bits wide: enough for the full 1..255 MAX_LOCK range.
   localparam logic [7:0] LP_MAX_LOCK = 8'(MAX_LOCK);

   // Identifies a requester; used both for the round-robin history and for
   // steering the read-return strobe.
   typedef enum logic {
      GNT_M0 = 1'b0,
      GNT_M1 = 1'b1
   } gnt_e;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic w_req0;
   logic w_req1;
   logic w_rd0;
   logic w_rd1;

   // A simultaneous read+write is a write; the read half is dropped so it
   // never produces a readdatavalid.
   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;
   assign w_rd0  = m0_read & ~m0_write;
   assign w_rd1  = m1_read & ~m1_write;

   // ---------------------------------------------------------------------------
   // Arbitration state
   // ---------------------------------------------------------------------------
   gnt_e       r_last_gnt;
   logic [7:0] r_lock_cnt;
   logic [7:0] w_lock_cnt_nxt;
   logic       r_rd_pend;
   gnt_e       r_rd_id;

   logic w_lock_hold;
   logic w_gnt0;
   logic w_gnt1;
   logic w_any_gnt;
   logic w_acc_rd;

   // m1 keeps the RAM on a tie only while it holds the lock, it was the last
   // winner and its burst budget is not yet used up.
   assign w_lock_hold = (r_last_gnt == GNT_M1) & m1_lock & w_req1 &
                        (r_lock_cnt < LP_MAX_LOCK);

   // Grant selection: single requester wins outright; a tie goes to the
   // requester not granted last unless the m1 lock is holding the RAM.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the block leaves it unassigned and infers a latch.
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_req0 && w_req1) begin
         if (w_lock_hold || (r_last_gnt == GNT_M0)) begin
            w_gnt1 = 1'b1;
         end else begin
            w_gnt0 = 1'b1;
         end
      end else begin
         w_gnt0 = w_req0;
         w_gnt1 = w_req1;
      end
   end

   assign w_any_gnt = w_gnt0 | w_gnt1;
   assign w_acc_rd  = (w_gnt0 & w_rd0) | (w_gnt1 & w_rd1);

   // Lock budget: counts m1 grants that actually made m0 wait; any m0 grant
   // or a dropped lock restarts the burst budget.
   always_comb begin
      w_lock_cnt_nxt = r_lock_cnt;
      if (w_gnt0 || !m1_lock) begin
         w_lock_cnt_nxt = 8'd0;
      end else if (w_gnt1 && w_req0) begin
         w_lock_cnt_nxt = r_lock_cnt + 8'd1;
      end
   end

   // Round-robin history and lock budget; last_gnt only moves when someone
   // is actually granted, and resets to m1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
         r_last_gnt <= GNT_M1;
         r_lock_cnt <= 8'd0;
      end else begin
         r_lock_cnt <= w_lock_cnt_nxt;
         if (w_any_gnt) begin
            r_last_gnt <= w_gnt1 ? GNT_M1 : GNT_M0;
         end
      end
   end

   // Read-return tracking: remembers who issued the read accepted this cycle
   // so the RAM data arriving next cycle is flagged for the right requester.
   // Reset discards any return still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_pend <= 1'b0;
         r_rd_id   <= GNT_M0;
      end else begin
         r_rd_pend <= w_acc_rd;
         if (w_acc_rd) begin
            r_rd_id <= w_gnt1 ? GNT_M1 : GNT_M0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Requester-side outputs
   // ---------------------------------------------------------------------------
   assign m0_waitrequest = w_req0 & ~w_gnt0;
   assign m1_waitrequest = w_req1 & ~w_gnt1;

   // Both requesters see the RAM data bus; only the strobe is steered.
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;
   assign m0_readdatavalid = r_rd_pend & (r_rd_id == GNT_M0);
   assign m1_readdatavalid = r_rd_pend & (r_rd_id == GNT_M1);

   // ---------------------------------------------------------------------------
   // RAM drive: mux the granted requester; idle cycles park on m0's values
   // with chipselect low.
   // ---------------------------------------------------------------------------
   assign ram_address    = w_gnt1 ? m1_address    : m0_address;
   assign ram_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
   assign ram_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
   assign ram_chipselect = w_any_gnt;
   assign ram_write      = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);
   assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_nios_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nios_ram_arbiter
//   Drives nios_ram_arbiter against a behavioural 2048x32 RAM with 1-cycle
//   read latency. A cycle-level reference model (who should win, what the RAM
//   should hold, which read comes back when) predicts every observable output.
// -----------------------------------------------------------------------------
module tb_nios_ram_arbiter;

   localparam int ADDR_W   = 11;
   localparam int DATA_W   = 32;
   localparam int BE_W     = DATA_W / 8;
   localparam int MAX_LOCK = 16;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
   logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
   logic              m0_read = 1'b0, m0_write = 1'b0;
   logic              m1_read = 1'b0, m1_write = 1'b0;
   logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
   logic              m1_lock = 1'b0;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] ram_address;
   logic [BE_W-1:0]   ram_byteenable;
   logic              ram_chipselect, ram_write, ram_clken;
   logic [DATA_W-1:0] ram_writedata;
   logic [DATA_W-1:0] ram_readdata;

   always #5 clk = ~clk;

   nios_ram_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_LOCK(MAX_LOCK)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .m0_address      (m0_address),
      .m0_byteenable   (m0_byteenable),
      .m0_read         (m0_read),
      .m0_write        (m0_write),
      .m0_writedata    (m0_writedata),
      .m0_waitrequest  (m0_waitrequest),
      .m0_readdata     (m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address      (m1_address),
      .m1_byteenable   (m1_byteenable),
      .m1_read         (m1_read),
      .m1_write        (m1_write),
      .m1_writedata    (m1_writedata),
      .m1_waitrequest  (m1_waitrequest),
      .m1_readdata     (m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .m1_lock         (m1_lock),
      .ram_address     (ram_address),
      .ram_byteenable  (ram_byteenable),
      .ram_chipselect  (ram_chipselect),
      .ram_write       (ram_write),
      .ram_writedata   (ram_writedata),
      .ram_clken       (ram_clken),
      .ram_readdata    (ram_readdata)
   );

   // Byte-lane merge of new data into an existing word.
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [BE_W-1:0]   be);
      logic [DATA_W-1:0] r;
      r = old_w;
      for (int b = 0; b < BE_W; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // Behavioural on-chip RAM: write completes in its cycle, read data appears
   // one cycle after the address.
   logic [DATA_W-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_chipselect && ram_clken) begin
         if (ram_write) ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
         else           ram_readdata <= ram_mem[ram_address];
      end
   end

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] shadow [DEPTH];
   bit                known  [DEPTH];
   int                mdl_last;       // requester that won most recently
   int                mdl_streak;     // m1 wins in a row that kept m0 waiting
   bit                mdl_pend;
   int                mdl_pend_id;
   bit                mdl_pend_known;
   logic [DATA_W-1:0] mdl_pend_data;

   int n_checks = 0;
   int n_errors = 0;

   // Observations from the most recent step, for directed scenario checks.
   logic              obs_wait0, obs_wait1, obs_v0, obs_v1;
   logic [DATA_W-1:0] obs_rd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mdl_last   = 1;
      mdl_streak = 0;
      mdl_pend   = 1'b0;
   endtask

   task automatic set_idle();
      m0_read = 1'b0; m0_write = 1'b0;
      m1_read = 1'b0; m1_write = 1'b0;
      m1_lock = 1'b0;
   endtask

   // One clock cycle: predict, sample at the falling edge, then advance the
   // model as the rising edge does. Entered and left just after a rising edge.
   task automatic step();
      int                win;
      bit                r0, r1, wr;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [BE_W-1:0]   be;
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      if (!r0 && !r1)      win = -1;
      else if (!r1)        win = 0;
      else if (!r0)        win = 1;
      else if (mdl_last == 1 && m1_lock && mdl_streak < MAX_LOCK) win = 1;
      else                 win = (mdl_last == 1) ? 0 : 1;

      @(negedge clk);
      obs_wait0 = m0_waitrequest; obs_wait1 = m1_waitrequest;
      obs_v0 = m0_readdatavalid;  obs_v1 = m1_readdatavalid;
      obs_rd0 = m0_readdata;
      check("wait0", 32'(m0_waitrequest), 32'(r0 && win != 0));
      check("wait1", 32'(m1_waitrequest), 32'(r1 && win != 1));
      check("ram_cs", 32'(ram_chipselect), 32'(win >= 0));
      check("ram_clken", 32'(ram_clken), 32'd1);
      wr = (win == 0) ? m0_write : (win == 1) ? m1_write : 1'b0;
      check("ram_write", 32'(ram_write), 32'(wr));
      a  = (win == 1) ? m1_address    : m0_address;
      d  = (win == 1) ? m1_writedata  : m0_writedata;
      be = (win == 1) ? m1_byteenable : m0_byteenable;
      if (win >= 0) begin
         check("ram_addr", 32'(ram_address), 32'(a));
         check("ram_be", 32'(ram_byteenable), 32'(be));
         if (wr) check("ram_wdata", ram_writedata, d);
      end
      check("rdv0", 32'(m0_readdatavalid), 32'(mdl_pend && mdl_pend_id == 0));
      check("rdv1", 32'(m1_readdatavalid), 32'(mdl_pend && mdl_pend_id == 1));
      if (mdl_pend && mdl_pend_known)
         check("rdata", (mdl_pend_id == 0) ? m0_readdata : m1_readdata, mdl_pend_data);

      mdl_pend = 1'b0;
      if (win >= 0) begin
         if (wr) begin
            shadow[a] = merge(shadow[a], d, be);
            if (be == '1) known[a] = 1'b1;
         end else begin
            mdl_pend       = 1'b1;
            mdl_pend_id    = win;
            mdl_pend_data  = shadow[a];
            mdl_pend_known = known[a];
         end
         mdl_last = win;
      end
      if (win == 0 || !m1_lock) mdl_streak = 0;
      else if (win == 1 && r0)  mdl_streak++;

      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse: assert just after a rising edge, release at
   // the falling edge. Any in-flight read return must vanish immediately.
   task automatic pulse_reset();
      set_idle();
      reset_n = 1'b0;
      #1;
      check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
      check("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
      check("rst_wait0", 32'(m0_waitrequest), 32'd0);
      check("rst_wait1", 32'(m1_waitrequest), 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int m0_wins;

   initial begin
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      model_reset();
      pulse_reset();

      // Write then read back on m0 alone.
      m0_write = 1'b1; m0_address = 11'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      step();
      check("t1_wr_wait0", 32'(obs_wait0), 32'd0);
      m0_write = 1'b0; m0_read = 1'b1;
      step();
      check("t1_rd_wait0", 32'(obs_wait0), 32'd0);
      set_idle();
      step();
      check("t1_v0", 32'(obs_v0), 32'd1);
      check("t1_data", obs_rd0, 32'hDEADBEEF);
      check("t1_v1", 32'(obs_v1), 32'd0);

      // Partial write by m1 over a full write by m0.
      m0_write = 1'b1; m0_address = 11'h7FF; m0_writedata = 32'h11223344; m0_byteenable = 4'hF;
      step();
      m0_write = 1'b0;
      m1_write = 1'b1; m1_address = 11'h7FF; m1_writedata = 32'hAABBCCDD; m1_byteenable = 4'h3;
      step();
      m1_write = 1'b0;
      m0_read = 1'b1; m0_address = 11'h7FF;
      step();
      set_idle();
      step();
      check("t4_v0", 32'(obs_v0), 32'd1);
      check("t4_data", obs_rd0, 32'h1122CCDD);

      // Read and write together is a write.
      m0_read = 1'b1; m0_write = 1'b1; m0_address = 11'h010; m0_writedata = 32'h5; m0_byteenable = 4'hF;
      step();
      set_idle();
      step();
      check("t6_no_valid", 32'(obs_v0), 32'd0);
      m0_read = 1'b1; m0_address = 11'h010;
      step();
      set_idle();
      step();
      check("t6_v0", 32'(obs_v0), 32'd1);
      check("t6_data", obs_rd0, 32'h5);

      // Simultaneous reads, reset in the following cycle.
      m0_read = 1'b1; m0_address = 11'h005;
      m1_read = 1'b1; m1_address = 11'h7FF;
      step();
      pulse_reset();
      step();
      check("t5_no_v0", 32'(obs_v0), 32'd0);
      check("t5_no_v1", 32'(obs_v1), 32'd0);

      // Continuous reads from both, no lock: strict alternation from m0.
      m0_read = 1'b1; m0_address = 11'h005;
      m1_read = 1'b1; m1_address = 11'h7FF;
      for (int k = 0; k < 8; k++) begin
         step();
         check("t2_wait0", 32'(obs_wait0), 32'(k % 2));
         check("t2_wait1", 32'(obs_wait1), 32'((k + 1) % 2));
         if (k > 0) check("t2_v0", 32'(obs_v0), 32'(k % 2));
      end

      // Locked m1 write stream against a waiting m0.
      pulse_reset();
      m0_read = 1'b1; m0_address = 11'h005;
      m1_write = 1'b1; m1_lock = 1'b1; m1_byteenable = 4'hF;
      m0_wins = 0;
      for (int k = 0; k < 40; k++) begin
         m1_address   = 11'(12'h100 + k);
         m1_writedata = 32'hC0DE0000 + 32'(k);
         step();
         if (!obs_wait0) m0_wins++;
         check("t3_m0_gnt", 32'(!obs_wait0), 32'(k == 16 || k == 33));
      end
      check("t3_m0_wins", 32'(m0_wins), 32'd2);
      set_idle();
      step();

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         if (i % 200 == 199) pulse_reset();
         m0_read       = ($urandom_range(0, 9) < 6);
         m0_write      = ($urandom_range(0, 9) < 3);
         m1_read       = ($urandom_range(0, 9) < 6);
         m1_write      = ($urandom_range(0, 9) < 3);
         m0_address    = 11'($urandom_range(0, 15));
         m1_address    = 11'($urandom_range(0, 15));
         m0_byteenable = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         m1_byteenable = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         m0_writedata  = $urandom;
         m1_writedata  = $urandom;
         if ($urandom_range(0, 19) == 0) m1_lock = ~m1_lock;
         step();
      end
      set_idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
